// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a write FIFO.
// Frames are emitted back to back while the FIFO holds words.
`ifndef B115200
`define B115200 104
`endif

module uart_tx_fifo #(
  parameter int BAUD       = `B115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          clear_ovf,
  output logic                          tx,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD);
  localparam int IW = 4;
  localparam logic ODD = (PARITY == 1);
  localparam logic HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic                 ovf_q;

  state_t               state;
  state_t               state_n;
  logic [BW-1:0]        bcnt;
  logic [BW-1:0]        bcnt_n;
  logic [IW-1:0]        bidx;
  logic [IW-1:0]        bidx_n;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 tx_q;
  logic                 tx_d;
  logic                 busy_q;

  logic                 push;
  logic                 pop;
  logic                 shift;
  logic                 bit_end;
  logic                 have_word;
  logic [DATA_BITS-1:0] head;

  assign ready      = (count < CW'(FIFO_DEPTH));
  assign push       = start & ready;
  assign have_word  = (count != '0);
  assign bit_end    = (bcnt == BW'(BAUD - 1));
  assign head       = mem[rptr];

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count;
  assign overflow   = ovf_q;

  // Storage is not reset; the pointers alone define what is queued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (start && !ready) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bit_end ? '0 : bcnt + BW'(1);
    bidx_n  = bidx;
    pop     = 1'b0;
    shift   = 1'b0;
    unique case (state)
      S_IDLE: begin
        bcnt_n = '0;
        bidx_n = '0;
        if (have_word) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bidx_n  = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bidx == IW'(DATA_BITS - 1)) begin
            bidx_n  = '0;
            state_n = HAS_PAR ? S_PAR : S_STOP;
          end else begin
            bidx_n = bidx + IW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          bidx_n  = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bidx == IW'(STOP_BITS - 1)) begin
            bidx_n = '0;
            if (have_word) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bidx_n = bidx + IW'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg[0];
      S_PAR:   tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  // tx/busy trail the state by one cycle so the pin is a clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      bcnt   <= '0;
      bidx   <= '0;
      shreg  <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      bidx   <= bidx_n;
      tx_q   <= tx_d;
      busy_q <= (state != S_IDLE);
      if (pop) begin
        shreg <= head;
        par_q <= (^head) ^ ODD;
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule
